// File: rtl/tis_node.sv
// tis_node: parametrised TIS-style execution node.
//
// A single-issue node that fetches from a loadable program memory and runs
// one instruction per cycle. Accumulator arithmetic saturates to +/-SAT_MAX.
// Neighbour ports use blocking valid/ready handshakes, so nodes can be tiled
// into a mesh.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   run                    1 = execute, 0 = hold all state
//   plen                   program length in words (0 = nothing executes)
//   prog_we/addr/wdata     program memory write port, usable at any time
//   in_valid/data/ready    neighbour input ports, N_PORTS lanes
//   out_valid/data/ready   neighbour output ports; one shared word on all lanes
//   pc, acc, bak           architectural registers, exposed for debug display
//   blocked                current instruction is stalled on a port
//
// Optional build macro TIS_NODE_PERF_EN adds the retire_cnt and stall_cnt
// outputs, both 32-bit wrapping counters.
module tis_node #(
    parameter int DATA_W     = 11,
    parameter int SAT_MAX    = 999,
    parameter int PROG_DEPTH = 16,
    parameter int N_PORTS    = 4,
    parameter int PC_W       = $clog2(PROG_DEPTH),
    parameter int INSTR_W    = 10 + DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic [PC_W:0]               plen,
    input  logic                        prog_we,
    input  logic [PC_W-1:0]             prog_addr,
    input  logic [INSTR_W-1:0]          prog_wdata,
    input  logic [N_PORTS-1:0]          in_valid,
    input  logic [N_PORTS*DATA_W-1:0]   in_data,
    output logic [N_PORTS-1:0]          in_ready,
    output logic [N_PORTS-1:0]          out_valid,
    output logic [N_PORTS*DATA_W-1:0]   out_data,
    input  logic [N_PORTS-1:0]          out_ready,
    output logic [PC_W-1:0]             pc,
    output logic [DATA_W-1:0]           acc,
    output logic [DATA_W-1:0]           bak,
    output logic                        blocked
`ifdef TIS_NODE_PERF_EN
    ,
    output logic [31:0]                 retire_cnt,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int XW = DATA_W + 1;          // arithmetic width, never overflows
    localparam int JW = DATA_W + PC_W + 2;   // JRO target width
    localparam logic signed [XW-1:0] SMAX = XW'(SAT_MAX);
    localparam logic signed [XW-1:0] SMIN = -SMAX;

    localparam logic [3:0] OP_SWP = 4'h1, OP_SAV = 4'h2, OP_NEG = 4'h3,
                           OP_ADD = 4'h4, OP_SUB = 4'h5, OP_MOV = 4'h6,
                           OP_JMP = 4'h7, OP_JEZ = 4'h8, OP_JNZ = 4'h9,
                           OP_JGZ = 4'hA, OP_JLZ = 4'hB, OP_JRO = 4'hC;

    typedef struct packed {
        logic [3:0]        op;
        logic [2:0]        src;
        logic [2:0]        dst;
        logic [DATA_W-1:0] imm;
    } instr_t;

    typedef enum logic {EXEC, WRITE} state_t;

    logic [INSTR_W-1:0] mem [PROG_DEPTH];
    instr_t             ins;
    state_t             state, state_n;
    logic [PC_W-1:0]    pc_n;
    logic [DATA_W-1:0]  acc_n, bak_n, wbuf, wbuf_n;
    logic [N_PORTS-1:0] ov_n, dst_hot;

    logic [N_PORTS-1:0][DATA_W-1:0] in_lane;
    logic [DATA_W-1:0]  src_val;
    logic               port_vld, active, uses_src, src_port, dst_port;
    logic               rd_port, stall, hs;
    logic signed [XW-1:0] acc_x, src_x;
    logic [PC_W:0]      pinc, plen_m1;
    logic [PC_W-1:0]    pc_seq, jmp_pc, jro_pc;
    logic signed [JW-1:0] jsum, plen_x;

    function automatic logic [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SMAX)      return SMAX[DATA_W-1:0];
        else if (v < SMIN) return SMIN[DATA_W-1:0];
        else               return v[DATA_W-1:0];
    endfunction

    // Program memory: no reset, so a loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_wdata;
    end

    // Combinational fetch: a write to mem[pc] is seen on the following cycle.
    assign ins     = mem[pc];
    assign in_lane = in_data;
    assign active  = run & (plen != '0);

    assign uses_src = (ins.op == OP_ADD) | (ins.op == OP_SUB) |
                      (ins.op == OP_MOV) | (ins.op == OP_JRO);
    assign src_port = ins.src[2] & ({1'b0, ins.src[1:0]} < 3'(N_PORTS));
    assign dst_port = ins.dst[2] & ({1'b0, ins.dst[1:0]} < 3'(N_PORTS));
    assign rd_port  = uses_src & src_port;

    always_comb begin
        src_val  = '0;
        port_vld = 1'b0;
        dst_hot  = '0;
        case (ins.src)
            3'd0:    src_val = acc;
            3'd2:    src_val = ins.imm;
            default: src_val = '0;
        endcase
        for (int k = 0; k < N_PORTS; k++) begin
            if (ins.src == 3'(4 + k)) begin
                src_val  = in_lane[k];
                port_vld = in_valid[k];
            end
            if (ins.dst == 3'(4 + k)) dst_hot[k] = 1'b1;
        end
    end

    assign stall = rd_port & ~port_vld;
    assign hs    = |(out_valid & out_ready);

    // in_ready is decoded from the instruction alone; it never looks at
    // out_ready, so there is no cross-port combinational path.
    for (genvar k = 0; k < N_PORTS; k++) begin : g_rdy
        assign in_ready[k] = rst_n & active & (state == EXEC) & rd_port &
                             (ins.src[1:0] == 2'(k));
    end

    assign out_data = {N_PORTS{wbuf}};
    assign blocked  = active & (((state == EXEC) & stall) |
                                ((state == WRITE) & ~hs));

    assign acc_x = {acc[DATA_W-1], acc};
    assign src_x = {src_val[DATA_W-1], src_val};

    // Next-pc candidates.
    assign pinc    = {1'b0, pc} + 1'b1;
    assign plen_m1 = plen - 1'b1;
    assign pc_seq  = (pinc >= plen) ? '0 : pinc[PC_W-1:0];
    assign jmp_pc  = ({1'b0, ins.imm[PC_W-1:0]} >= plen) ? '0 : ins.imm[PC_W-1:0];
    assign jsum    = $signed({{(JW-PC_W){1'b0}}, pc}) +
                     $signed({{(JW-DATA_W){src_val[DATA_W-1]}}, src_val});
    assign plen_x  = $signed({{(JW-PC_W-1){1'b0}}, plen});
    assign jro_pc  = (jsum < 0)       ? '0 :
                     (jsum >= plen_x) ? plen_m1[PC_W-1:0] : jsum[PC_W-1:0];

    always_comb begin
        state_n = state;
        pc_n    = pc;
        acc_n   = acc;
        bak_n   = bak;
        wbuf_n  = wbuf;
        ov_n    = out_valid;
        if (active) begin
            if (state == EXEC) begin
                if (!stall) begin
                    pc_n = pc_seq;
                    case (ins.op)
                        OP_SWP: begin acc_n = bak; bak_n = acc; end
                        OP_SAV: bak_n = acc;
                        OP_NEG: acc_n = sat(-acc_x);
                        OP_ADD: acc_n = sat(acc_x + src_x);
                        OP_SUB: acc_n = sat(acc_x - src_x);
                        OP_MOV: begin
                            if (dst_port) begin
                                // Word is held in wbuf and offered from WRITE;
                                // pc advances only once it is taken.
                                pc_n    = pc;
                                wbuf_n  = src_val;
                                ov_n    = dst_hot;
                                state_n = WRITE;
                            end else if (ins.dst == 3'd0) begin
                                acc_n = sat(src_x);
                            end
                        end
                        OP_JMP: pc_n = jmp_pc;
                        OP_JEZ: if (acc == '0) pc_n = jmp_pc;
                        OP_JNZ: if (acc != '0) pc_n = jmp_pc;
                        OP_JGZ: if (!acc[DATA_W-1] && acc != '0) pc_n = jmp_pc;
                        OP_JLZ: if (acc[DATA_W-1]) pc_n = jmp_pc;
                        OP_JRO: pc_n = jro_pc;
                        default: ;
                    endcase
                end
            end else if (hs) begin
                ov_n    = '0;
                pc_n    = pc_seq;
                state_n = EXEC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EXEC;
            pc        <= '0;
            acc       <= '0;
            bak       <= '0;
            wbuf      <= '0;
            out_valid <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            acc       <= acc_n;
            bak       <= bak_n;
            wbuf      <= wbuf_n;
            out_valid <= ov_n;
        end
    end

`ifdef TIS_NODE_PERF_EN
    logic retire;
    assign retire = active & (((state == EXEC) & ~stall &
                               ~((ins.op == OP_MOV) & dst_port)) |
                              ((state == WRITE) & hs));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (retire)        retire_cnt <= retire_cnt + 32'd1;
            if (run & blocked) stall_cnt  <= stall_cnt + 32'd1;
        end
    end
`else
    // Performance counters compiled out.
`endif

endmodule
